uart_tx_framer: RTL and testbench

//  Buffered UART transmitter (FPGA -> PC), the outbound counterpart of the board's UART receiver path.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_tx_fifo.sv | 68 ++++++
 rtl/uart_tx_framer.sv | 187 ++++++++++++++++++
 tb/tb_uart_tx_framer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default line parameters.
// The receiver imports this package as well.
package uart_pkg;

  localparam int DEFAULT_CLK_PER_BIT = 868;  // 100 MHz / 115200 baud
  localparam int DEFAULT_DATA_WIDTH  = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    PARITY  = 3'd3,
    STOP    = 3'd4,
    CLEANUP = 3'd5
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO buffering bytes between user logic and the framer.
// The read port is combinational (first-word fall-through), so the framer can
// take a byte in the same cycle it pops it. Storage is not reset; only the
// pointers and the count are, which is enough to flush the FIFO.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_wdata,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_rdata,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign o_full  = (count_q == FULL_CNT);
  assign o_empty = (count_q == '0);
  assign o_count = count_q;
  assign o_rdata = mem_q[rd_ptr_q];

  // A full FIFO ignores pushes and an empty one ignores pops, so count stays in 0..DEPTH.
  assign push_ok = i_push & ~o_full;
  assign pop_ok  = i_pop  & ~o_empty;

  // Pointer and occupancy next-state; pointers wrap naturally since DEPTH is a power of 2.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d  = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer/count registers with synchronous flush.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Data storage write port.
  always_ff @(posedge i_clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= i_wdata;
  end

endmodule

// File: rtl/uart_tx_framer.sv
// Buffered UART transmitter: bytes enter a FIFO over valid/ready and leave as
// LSB-first frames (start, data, optional parity, 1 or 2 stop bits), idle high.
// All line outputs are registered so the TX pin is glitch-free.
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = DEFAULT_CLK_PER_BIT,
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int FIFO_DEPTH  = 4,
  parameter int PARITY_EN   = 0,
  parameter int PARITY_ODD  = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_tx_valid,
  input  logic [DATA_WIDTH-1:0]       i_tx_data,
  output logic                        o_tx_ready,
  output logic                        o_tx_serial,
  output logic                        o_tx_active,
  output logic                        o_tx_done,
  output logic [$clog2(FIFO_DEPTH):0] o_fifo_count
);

  localparam int CW = $clog2(CLK_PER_BIT);
  // bit_cnt also counts stop bits, so keep at least one bit even for tiny payloads.
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CW-1:0] CLK_LAST  = CW'(CLK_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic          PAR_ODD   = (PARITY_ODD != 0);

  tx_state_e             state_q, state_d;
  logic [CW-1:0]         clk_cnt_q, clk_cnt_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_q, par_d;
  logic                  serial_q, serial_d;
  logic                  active_q, active_d;
  logic                  done_q, done_d;

  logic                  fifo_full, fifo_empty, pop;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  bit_end, start_frame;

  uart_tx_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (i_tx_valid & o_tx_ready),
    .i_wdata (i_tx_data),
    .i_pop   (pop),
    .o_rdata (fifo_rdata),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_count (o_fifo_count)
  );

  assign o_tx_ready  = ~fifo_full;
  assign o_tx_serial = serial_q;
  assign o_tx_active = active_q;
  assign o_tx_done   = done_q;

  assign bit_end     = (clk_cnt_q == CLK_LAST);
  // A new frame may begin from IDLE or straight out of CLEANUP (back-to-back).
  assign start_frame = ((state_q == IDLE) || (state_q == CLEANUP)) && !fifo_empty;

  // Framer next-state: bit timing, shifting, and registered line outputs.
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    serial_d  = serial_q;
    active_d  = active_q;
    done_d    = 1'b0;
    pop       = 1'b0;

    if ((state_q == START) || (state_q == DATA) || (state_q == PARITY) || (state_q == STOP))
      clk_cnt_d = bit_end ? '0 : clk_cnt_q + CW'(1);

    case (state_q)
      IDLE: begin
        serial_d = 1'b1;
        active_d = 1'b0;
      end
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          serial_d  = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d = '0;
            if (PARITY_EN != 0) begin
              state_d  = PARITY;
              serial_d = par_q;
            end else begin
              state_d  = STOP;
              serial_d = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
            serial_d  = shift_q[0];
            shift_d   = shift_q >> 1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d  = STOP;
          serial_d = 1'b1;
        end
      end
      STOP: begin
        serial_d = 1'b1;
        if (bit_end) begin
          if (bit_cnt_q == STOP_LAST) begin
            // Active ends with the last stop-bit cycle; done marks the CLEANUP cycle.
            state_d   = CLEANUP;
            active_d  = 1'b0;
            done_d    = 1'b1;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
      CLEANUP: begin
        serial_d = 1'b1;
        active_d = 1'b0;
        state_d  = IDLE;
      end
      default: begin
        state_d   = IDLE;
        serial_d  = 1'b1;
        active_d  = 1'b0;
        clk_cnt_d = '0;
        bit_cnt_d = '0;
      end
    endcase

    // Frame launch overrides the IDLE/CLEANUP defaults above.
    if (start_frame) begin
      pop       = 1'b1;
      shift_d   = fifo_rdata;
      par_d     = (^fifo_rdata) ^ PAR_ODD;
      serial_d  = 1'b0;
      active_d  = 1'b1;
      clk_cnt_d = '0;
      bit_cnt_d = '0;
      state_d   = START;
    end
  end

  // Framer state register; reset abandons any frame in flight without a done pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      serial_q  <= 1'b1;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      serial_q  <= serial_d;
      active_q  <= active_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer. Four instances cover the parameter sets:
// 0 = 16 clk/bit 8N1, 1 = 16 clk/bit even parity 2 stop, 2 = odd parity 2 stop,
// 3 = default 868 clk/bit 8N1. 'sel' chooses which one is driven and observed.
module tb_uart_tx_framer;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] vld;
  logic [7:0] tx_data;
  logic [3:0] rdy, ser, act, dn;
  logic [2:0] cnt [4];

  int   sel = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   cyc = 0;
  int   act_cnt;
  int   first_err;
  logic par_seen;
  logic [7:0] pb [8];   // bytes to push
  logic [7:0] fb [8];   // bytes expected on the line

  logic       ser_m, act_m, dn_m, rdy_m;
  logic [2:0] cnt_m;
  assign ser_m = ser[sel[1:0]];
  assign act_m = act[sel[1:0]];
  assign dn_m  = dn[sel[1:0]];
  assign rdy_m = rdy[sel[1:0]];
  assign cnt_m = cnt[sel[1:0]];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_framer #(.CLK_PER_BIT(16)) u_d0 (
    .i_clk(clk), .i_rst(rst), .i_tx_valid(vld[0]), .i_tx_data(tx_data),
    .o_tx_ready(rdy[0]), .o_tx_serial(ser[0]), .o_tx_active(act[0]),
    .o_tx_done(dn[0]), .o_fifo_count(cnt[0]));

  uart_tx_framer #(.CLK_PER_BIT(16), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_d1 (
    .i_clk(clk), .i_rst(rst), .i_tx_valid(vld[1]), .i_tx_data(tx_data),
    .o_tx_ready(rdy[1]), .o_tx_serial(ser[1]), .o_tx_active(act[1]),
    .o_tx_done(dn[1]), .o_fifo_count(cnt[1]));

  uart_tx_framer #(.CLK_PER_BIT(16), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_d2 (
    .i_clk(clk), .i_rst(rst), .i_tx_valid(vld[2]), .i_tx_data(tx_data),
    .o_tx_ready(rdy[2]), .o_tx_serial(ser[2]), .o_tx_active(act[2]),
    .o_tx_done(dn[2]), .o_fifo_count(cnt[2]));

  uart_tx_framer u_d3 (
    .i_clk(clk), .i_rst(rst), .i_tx_valid(vld[3]), .i_tx_data(tx_data),
    .o_tx_ready(rdy[3]), .o_tx_serial(ser[3]), .o_tx_active(act[3]),
    .o_tx_done(dn[3]), .o_fifo_count(cnt[3]));

  // Expected line level for bit slot i of a frame carrying byte b.
  function automatic logic frame_bit(input logic [7:0] b, input int i, input bit pen, input bit podd);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
    if (pen && i == 9) return (^b) ^ podd;
    return 1'b1;
  endfunction

  // Push pb[0..n-1] with valid held; called and returns on a negedge.
  task automatic push_list(input int n, input int max_wait, output int to);
    int w;
    to = 0;
    for (int i = 0; i < n; i++) begin
      tx_data = pb[i];
      vld = 4'b0001 << sel;
      w = 0;
      while (rdy_m !== 1'b1 && w < max_wait) begin @(negedge clk); w++; end
      if (rdy_m !== 1'b1) to++;
      @(negedge clk);
    end
    vld = 4'b0000;
  endtask

  // Cycle-by-cycle capture of nfr back-to-back frames against fb[]; returns error counts.
  task automatic capture_frames(input int nfr, input int cpb, input bit pen, input bit podd,
                                input int nstop, input int max_wait,
                                output int to, output int se, output int ae, output int de,
                                output int dcnt);
    int nb, flen, w, f, r;
    logic es, ea, ed;
    to = 0; se = 0; ae = 0; de = 0; dcnt = 0; act_cnt = 0; first_err = -1;
    nb   = 1 + 8 + int'(pen) + nstop;
    flen = nb * cpb;
    w = 0;
    while (ser_m !== 1'b0 && w < max_wait) begin @(negedge clk); w++; end
    if (ser_m !== 1'b0) begin to = 1; return; end
    for (int t = 0; t < nfr * (flen + 1) + 4; t++) begin
      f = t / (flen + 1);
      r = t % (flen + 1);
      if (f < nfr && r < flen) begin es = frame_bit(fb[f], r / cpb, pen, podd); ea = 1'b1; ed = 1'b0; end
      else if (f < nfr)        begin es = 1'b1; ea = 1'b0; ed = 1'b1; end
      else                     begin es = 1'b1; ea = 1'b0; ed = 1'b0; end
      if (ser_m !== es) begin se++; if (first_err < 0) first_err = t; end
      if (act_m !== ea) ae++;
      if (dn_m  !== ed) de++;
      if (act_m === 1'b1) act_cnt++;
      if (dn_m  === 1'b1) dcnt++;
      if (pen && f == 0 && r == 9 * cpb + cpb / 2) par_seen = ser_m;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; vld = '0; tx_data = '0; sel = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    total_cnt++; if (ser_m !== 1'b1) $display("FAIL reset_serial: got %b expected 1", ser_m); else pass_cnt++;
    total_cnt++; if (act_m !== 1'b0) $display("FAIL reset_active: got %b expected 0", act_m); else pass_cnt++;
    total_cnt++; if (dn_m !== 1'b0) $display("FAIL reset_done: got %b expected 0", dn_m); else pass_cnt++;
    total_cnt++; if (rdy !== 4'hF) $display("FAIL reset_ready: got %b expected 1111", rdy); else pass_cnt++;
    total_cnt++; if (cnt_m !== 3'd0) $display("FAIL reset_count: got %0d expected 0", cnt_m); else pass_cnt++;
  endtask

  task automatic test_single();
    int to, cto, se, ae, de, dc;
    sel = 0; pb[0] = 8'h41; fb[0] = 8'h41;
    fork
      begin
        push_list(1, 10, to);
        total_cnt++; if (ser_m !== 1'b1) $display("FAIL lat_accept_edge: got %b expected 1", ser_m); else pass_cnt++;
        total_cnt++; if (cnt_m !== 3'd1) $display("FAIL lat_count: got %0d expected 1", cnt_m); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (ser_m !== 1'b0) $display("FAIL lat_start_low: got %b expected 0", ser_m); else pass_cnt++;
      end
      capture_frames(1, 16, 1'b0, 1'b0, 1, 50, cto, se, ae, de, dc);
    join
    total_cnt++; if (to !== 0) $display("FAIL single_push_to: got %0d expected 0", to); else pass_cnt++;
    total_cnt++; if (cto !== 0) $display("FAIL single_start_to: got %0d expected 0", cto); else pass_cnt++;
    total_cnt++; if (se !== 0) $display("FAIL single_serial: got %0d errs (first t=%0d) expected 0", se, first_err); else pass_cnt++;
    total_cnt++; if (ae !== 0) $display("FAIL single_active: got %0d errs expected 0", ae); else pass_cnt++;
    total_cnt++; if (de !== 0) $display("FAIL single_done_pos: got %0d errs expected 0", de); else pass_cnt++;
    total_cnt++; if (act_cnt !== 160) $display("FAIL single_active_len: got %0d expected 160", act_cnt); else pass_cnt++;
    total_cnt++; if (dc !== 1) $display("FAIL single_done_cnt: got %0d expected 1", dc); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int to, cto, se, ae, de, dc, c0, c1;
    sel = 0;
    pb[0] = 8'h55; pb[1] = 8'hAA; pb[2] = 8'h0F;
    fb[0] = 8'h55; fb[1] = 8'hAA; fb[2] = 8'h0F;
    fork
      begin
        c0 = cyc;
        push_list(3, 10, to);
        c1 = cyc;
        total_cnt++; if (cnt_m !== 3'd2) $display("FAIL b2b_count: got %0d expected 2", cnt_m); else pass_cnt++;
      end
      capture_frames(3, 16, 1'b0, 1'b0, 1, 50, cto, se, ae, de, dc);
    join
    total_cnt++; if (to !== 0) $display("FAIL b2b_push_to: got %0d expected 0", to); else pass_cnt++;
    total_cnt++; if (c1 - c0 !== 3) $display("FAIL b2b_push_cycles: got %0d expected 3", c1 - c0); else pass_cnt++;
    total_cnt++; if (cto !== 0) $display("FAIL b2b_start_to: got %0d expected 0", cto); else pass_cnt++;
    total_cnt++; if (se !== 0) $display("FAIL b2b_serial: got %0d errs (first t=%0d) expected 0", se, first_err); else pass_cnt++;
    total_cnt++; if (ae !== 0) $display("FAIL b2b_active: got %0d errs expected 0", ae); else pass_cnt++;
    total_cnt++; if (de !== 0) $display("FAIL b2b_done_pos: got %0d errs expected 0", de); else pass_cnt++;
    total_cnt++; if (dc !== 3) $display("FAIL b2b_done_cnt: got %0d expected 3", dc); else pass_cnt++;
  endtask

  task automatic test_fifo_full();
    int to, cto, se, ae, de, dc, bad, rel_k, rel_cnt, after_cnt;
    logic saw_full, prev_rdy;
    sel = 0;
    for (int i = 0; i < 6; i++) begin pb[i] = 8'hA1 + 8'(i); fb[i] = 8'hA1 + 8'(i); end
    bad = 0; rel_k = -1; rel_cnt = -1; after_cnt = -1; saw_full = 1'b0; prev_rdy = 1'b1;
    fork
      push_list(6, 400, to);
      capture_frames(6, 16, 1'b0, 1'b0, 1, 50, cto, se, ae, de, dc);
      for (int k = 0; k < 400; k++) begin
        if (rdy_m !== (cnt_m != 3'd4)) bad++;
        if (cnt_m > 3'd4) bad++;
        if (rdy_m === 1'b0) saw_full = 1'b1;
        if (rel_k >= 0 && k == rel_k + 1) after_cnt = int'(cnt_m);
        if (rel_k < 0 && prev_rdy === 1'b0 && rdy_m === 1'b1) begin rel_k = k; rel_cnt = int'(cnt_m); end
        prev_rdy = rdy_m;
        @(negedge clk);
      end
    join
    total_cnt++; if (to !== 0) $display("FAIL full_push_to: got %0d expected 0", to); else pass_cnt++;
    total_cnt++; if (saw_full !== 1'b1) $display("FAIL full_ready_low: got %b expected 1", saw_full); else pass_cnt++;
    total_cnt++; if (bad !== 0) $display("FAIL full_ready_vs_count: got %0d errs expected 0", bad); else pass_cnt++;
    total_cnt++; if (rel_cnt !== 3) $display("FAIL full_release_count: got %0d expected 3", rel_cnt); else pass_cnt++;
    total_cnt++; if (after_cnt !== 4) $display("FAIL full_accept_next: got %0d expected 4", after_cnt); else pass_cnt++;
    total_cnt++; if (cto !== 0) $display("FAIL full_start_to: got %0d expected 0", cto); else pass_cnt++;
    total_cnt++; if (se !== 0) $display("FAIL full_order: got %0d errs (first t=%0d) expected 0", se, first_err); else pass_cnt++;
    total_cnt++; if (dc !== 6) $display("FAIL full_done_cnt: got %0d expected 6", dc); else pass_cnt++;
  endtask

  task automatic test_parity();
    int to, cto, se, ae, de, dc;
    for (int p = 1; p <= 2; p++) begin
      sel = p; pb[0] = 8'h07; fb[0] = 8'h07;
      par_seen = (p == 1) ? 1'b0 : 1'b1;
      fork
        push_list(1, 10, to);
        capture_frames(1, 16, 1'b1, (p == 2), 2, 50, cto, se, ae, de, dc);
      join
      total_cnt++; if (cto !== 0 || to !== 0) $display("FAIL par%0d_start_to: got %0d/%0d expected 0/0", p, cto, to); else pass_cnt++;
      total_cnt++; if (par_seen !== ((p == 1) ? 1'b1 : 1'b0)) $display("FAIL par%0d_bit: got %b expected %b", p, par_seen, (p == 1) ? 1'b1 : 1'b0); else pass_cnt++;
      total_cnt++; if (se !== 0) $display("FAIL par%0d_serial: got %0d errs (first t=%0d) expected 0", p, se, first_err); else pass_cnt++;
      total_cnt++; if (act_cnt !== 192) $display("FAIL par%0d_active_len: got %0d expected 192", p, act_cnt); else pass_cnt++;
      total_cnt++; if (de !== 0 || ae !== 0) $display("FAIL par%0d_done_active: got %0d/%0d errs expected 0/0", p, de, ae); else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    int to, cto, se, ae, de, dc, bad;
    sel = 0; pb[0] = 8'h3C; pb[1] = 8'h11; pb[2] = 8'h22;
    push_list(3, 10, to);
    total_cnt++; if (cnt_m !== 3'd2) $display("FAIL rmid_queued: got %0d expected 2", cnt_m); else pass_cnt++;
    repeat (60) @(negedge clk);
    total_cnt++; if (act_m !== 1'b1) $display("FAIL rmid_in_frame: got %b expected 1", act_m); else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total_cnt++; if (ser_m !== 1'b1) $display("FAIL rmid_serial: got %b expected 1", ser_m); else pass_cnt++;
    total_cnt++; if (cnt_m !== 3'd0) $display("FAIL rmid_count: got %0d expected 0", cnt_m); else pass_cnt++;
    total_cnt++; if (rdy_m !== 1'b1) $display("FAIL rmid_ready: got %b expected 1", rdy_m); else pass_cnt++;
    bad = 0;
    for (int k = 0; k < 200; k++) begin
      if (dn_m !== 1'b0 || ser_m !== 1'b1 || act_m !== 1'b0) bad++;
      @(negedge clk);
    end
    total_cnt++; if (bad !== 0) $display("FAIL rmid_quiet: got %0d errs expected 0", bad); else pass_cnt++;
    pb[0] = 8'h12; fb[0] = 8'h12;
    fork
      push_list(1, 10, to);
      capture_frames(1, 16, 1'b0, 1'b0, 1, 50, cto, se, ae, de, dc);
    join
    total_cnt++; if (cto !== 0) $display("FAIL rmid_new_start_to: got %0d expected 0", cto); else pass_cnt++;
    total_cnt++; if (se !== 0 || ae !== 0 || de !== 0) $display("FAIL rmid_new_frame: got %0d/%0d/%0d errs expected 0/0/0", se, ae, de); else pass_cnt++;
  endtask

  task automatic test_default_rate();
    int to, cto, se, ae, de, dc;
    sel = 3; pb[0] = 8'hFF; fb[0] = 8'hFF;
    fork
      push_list(1, 10, to);
      capture_frames(1, 868, 1'b0, 1'b0, 1, 50, cto, se, ae, de, dc);
    join
    total_cnt++; if (cto !== 0) $display("FAIL def_start_to: got %0d expected 0", cto); else pass_cnt++;
    total_cnt++; if (se !== 0) $display("FAIL def_serial: got %0d errs (first t=%0d) expected 0", se, first_err); else pass_cnt++;
    total_cnt++; if (act_cnt !== 8680) $display("FAIL def_frame_len: got %0d expected 8680", act_cnt); else pass_cnt++;
    total_cnt++; if (dc !== 1 || de !== 0) $display("FAIL def_done: got cnt %0d errs %0d expected 1/0", dc, de); else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1; vld = '0; tx_data = '0;
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_fifo_full();
    test_parity();
    test_reset_mid();
    test_default_rate();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", pass_cnt, total_cnt);
    $fatal(1, "timeout");
  end

endmodule
